// File: rtl/uart_word_channel_if.sv
// Word-side handshake plus the byte-level transmitter/receiver hookup for uart_word_channel.
// The slave modport is the channel itself; master is whatever sits around it.
interface uart_word_channel_if #(
   parameter int WORD_BYTES = 2
);
   logic [8*WORD_BYTES-1:0] word_in;
   logic                    word_valid;
   logic                    word_ready;
   logic [7:0]              tx_data;
   logic                    tx_wr;
   logic                    tx_en;
   logic                    tx_busy;
   logic                    rx_en;
   logic [7:0]              rx_data;
   logic                    rx_valid;
   logic                    rx_ferror;
   logic                    rx_perror;
   logic [8*WORD_BYTES-1:0] word_out;
   logic                    word_out_valid;
   logic                    word_err;
   logic                    rx_timeout;

   modport slave (
      input  word_in, word_valid, tx_busy, rx_data, rx_valid, rx_ferror, rx_perror,
      output word_ready, tx_data, tx_wr, tx_en, rx_en, word_out, word_out_valid,
             word_err, rx_timeout
   );

   modport master (
      output word_in, word_valid, tx_busy, rx_data, rx_valid, rx_ferror, rx_perror,
      input  word_ready, tx_data, tx_wr, tx_en, rx_en, word_out, word_out_valid,
             word_err, rx_timeout
   );
endinterface

// File: rtl/uart_word_channel.sv
// Word-level front end for a byte UART: splits words into transmitter writes and
// reassembles received bytes into words with sticky error status and an inter-byte timeout.
module uart_word_channel #(
   parameter int WORD_BYTES = 2,
   parameter bit MSB_FIRST  = 1'b1,
   parameter int RX_TIMEOUT = 4096
) (
   input logic clk,
   input logic reset,
   uart_word_channel_if.slave bus
);
   localparam int WORD_W = 8 * WORD_BYTES;
   localparam int IDX_W  = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
   localparam int TO_W   = $clog2(RX_TIMEOUT + 1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_BYTES - 1);
   localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(RX_TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, LOAD, WAIT_BUSY, WAIT_DONE} tx_state_t;

   tx_state_t         tx_state_reg;
   logic [WORD_W-1:0] shift_reg;
   logic [IDX_W-1:0]  tx_idx_reg;
   logic              en_reg;
   logic              word_ready_reg;
   logic              tx_wr_reg;
   logic [7:0]        tx_data_reg;

   logic [IDX_W-1:0]  rx_cnt_reg;
   logic              acc_err_reg;
   logic [TO_W-1:0]   to_cnt_reg;
   logic [WORD_W-1:0] asm_reg;
   logic [WORD_W-1:0] asm_next;
   logic [IDX_W-1:0]  slot;
   logic              byte_err;
   logic [WORD_W-1:0] word_out_reg;
   logic              word_out_valid_reg;
   logic              word_err_reg;
   logic              rx_timeout_reg;

   // The shift register always presents the next byte at its leading end.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tx_state_reg   <= IDLE;
         shift_reg      <= '0;
         tx_idx_reg     <= '0;
         en_reg         <= 1'b0;
         word_ready_reg <= 1'b0;
         tx_wr_reg      <= 1'b0;
         tx_data_reg    <= 8'h00;
      end else begin
         en_reg    <= 1'b1;
         tx_wr_reg <= 1'b0;
         case (tx_state_reg)
            IDLE: begin
               if (bus.word_valid && word_ready_reg) begin
                  shift_reg      <= bus.word_in;
                  tx_idx_reg     <= '0;
                  word_ready_reg <= 1'b0;
                  tx_state_reg   <= LOAD;
               end else begin
                  word_ready_reg <= en_reg;
               end
            end
            LOAD: begin
               if (!bus.tx_busy) begin
                  tx_data_reg  <= MSB_FIRST ? shift_reg[WORD_W-1 -: 8] : shift_reg[7:0];
                  shift_reg    <= MSB_FIRST ? (shift_reg << 8) : (shift_reg >> 8);
                  tx_wr_reg    <= 1'b1;
                  tx_state_reg <= WAIT_BUSY;
               end
            end
            WAIT_BUSY: begin
               if (bus.tx_busy) begin
                  tx_state_reg <= WAIT_DONE;
               end
            end
            WAIT_DONE: begin
               if (!bus.tx_busy) begin
                  if (tx_idx_reg == LAST_IDX) begin
                     word_ready_reg <= 1'b1;
                     tx_state_reg   <= IDLE;
                  end else begin
                     tx_idx_reg   <= tx_idx_reg + 1'b1;
                     tx_state_reg <= LOAD;
                  end
               end
            end
            default: tx_state_reg <= IDLE;
         endcase
      end
   end

   assign slot     = MSB_FIRST ? (LAST_IDX - rx_cnt_reg) : rx_cnt_reg;
   assign byte_err = bus.rx_ferror | bus.rx_perror;

   // asm_next already holds the incoming byte, so the last byte completes the word in one edge.
   generate
      for (genvar gi = 0; gi < WORD_BYTES; gi++) begin : g_slot
         assign asm_next[8*gi +: 8] = (bus.rx_valid && slot == IDX_W'(gi)) ?
                                      bus.rx_data : asm_reg[8*gi +: 8];
      end
   endgenerate

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rx_cnt_reg         <= '0;
         acc_err_reg        <= 1'b0;
         to_cnt_reg         <= '0;
         asm_reg            <= '0;
         word_out_reg       <= '0;
         word_out_valid_reg <= 1'b0;
         word_err_reg       <= 1'b0;
         rx_timeout_reg     <= 1'b0;
      end else begin
         word_out_valid_reg <= 1'b0;
         rx_timeout_reg     <= 1'b0;
         asm_reg            <= asm_next;
         if (bus.rx_valid) begin
            to_cnt_reg <= '0;
            if (rx_cnt_reg == LAST_IDX) begin
               word_out_reg       <= asm_next;
               word_out_valid_reg <= 1'b1;
               word_err_reg       <= acc_err_reg | byte_err;
               rx_cnt_reg         <= '0;
               acc_err_reg        <= 1'b0;
            end else begin
               rx_cnt_reg  <= rx_cnt_reg + 1'b1;
               acc_err_reg <= acc_err_reg | byte_err;
            end
         end else if (rx_cnt_reg != '0) begin
            // Expire on the edge where the count would reach RX_TIMEOUT.
            if (to_cnt_reg == TO_LAST) begin
               rx_cnt_reg     <= '0;
               acc_err_reg    <= 1'b0;
               to_cnt_reg     <= '0;
               rx_timeout_reg <= 1'b1;
            end else begin
               to_cnt_reg <= to_cnt_reg + 1'b1;
            end
         end
      end
   end

   assign bus.word_ready     = word_ready_reg;
   assign bus.tx_data        = tx_data_reg;
   assign bus.tx_wr          = tx_wr_reg;
   assign bus.tx_en          = en_reg;
   assign bus.rx_en          = en_reg;
   assign bus.word_out       = word_out_reg;
   assign bus.word_out_valid = word_out_valid_reg;
   assign bus.word_err       = word_err_reg;
   assign bus.rx_timeout     = rx_timeout_reg;
endmodule

// File: doc/uart_word_channel.md
Name: uart_word_channel

Overview:
Parametrised word-level front end for the UART byte transmitter and receiver. It serialises a WORD_BYTES-byte word into consecutive byte writes on the transmitter, and reassembles received bytes into a word with per-word error status and an inter-byte timeout. It generalises the fixed 16-bit two-packet channel in three ways: any word width, selectable byte order, and independent, concurrent TX and RX paths with a ready/valid handshake.

Parameters:
WORD_BYTES, 2, bytes per word; legal range is 1 or more.
MSB_FIRST, 1, 1 = most significant byte sent/received first; 0 = least significant byte first.
RX_TIMEOUT, 4096, clocks allowed after the last received byte of a partial word before that partial word is discarded; legal range is 1 or more.

Ports:
clk  in  1  system clock, all logic on its rising edge
reset  in  1  asynchronous, active-high reset
word_in  in  8*WORD_BYTES  word to transmit
word_valid  in  1  word_in is valid
word_ready  out  1  block can accept a word
tx_data  out  8  byte to the transmitter
tx_wr  out  1  one-cycle write strobe to the transmitter
tx_en  out  1  transmitter enable
tx_busy  in  1  transmitter busy
rx_en  out  1  receiver enable
rx_data  in  8  received byte
rx_valid  in  1  one-cycle pulse per received byte
rx_ferror  in  1  framing error, qualified by rx_valid
rx_perror  in  1  parity error, qualified by rx_valid
word_out  out  8*WORD_BYTES  last assembled word
word_out_valid  out  1  one-cycle pulse when word_out updates
word_err  out  1  error status of the current word_out
rx_timeout  out  1  one-cycle pulse when a partial word is dropped

Behaviour:
- Reset values (asynchronous): word_ready=0, tx_data=0, tx_wr=0, tx_en=0, rx_en=0, word_out=0, word_out_valid=0, word_err=0, rx_timeout=0. All internal counters and FSMs go to idle.
- tx_en and rx_en are registered. Both rise to 1 on the first clk edge after reset deasserts and stay 1.
- Reset asserted mid-operation aborts any word in flight. No partial word is delivered and tx_wr drops at once.

TX FSM, states IDLE, LOAD, WAIT_BUSY, WAIT_DONE:
- IDLE: word_ready=1 (registered; first 1 is on the cycle after tx_en rises). When word_valid && word_ready at an edge, latch word_in into the shift register, clear the byte index, go to LOAD. word_ready=0 in every other state.
- LOAD: when tx_busy=0, drive tx_data with the selected byte and pulse tx_wr for exactly one cycle, then go to WAIT_BUSY. If tx_busy=1, hold in LOAD without pulsing.
- WAIT_BUSY: wait for tx_busy=1, then go to WAIT_DONE. There is no timeout; the transmitter always raises busy after a write.
- WAIT_DONE: wait for tx_busy=0. On the last byte (index = WORD_BYTES-1) go to IDLE; otherwise increment the index and go to LOAD.
- Byte selection: MSB_FIRST=1 sends bits [8W-1:8W-8] first; MSB_FIRST=0 sends [7:0] first.
- Latency: a word accepted at edge N with tx_busy low produces tx_wr high in cycle N+1.
- tx_data holds its last value between writes.

RX path (runs concurrently with TX):
- Byte counter rx_cnt runs 0..WORD_BYTES-1.
- Sticky error flag acc_err.
- Timeout counter is $clog2(RX_TIMEOUT+1) bits wide.
- On rx_valid: place rx_data in the slot for rx_cnt, using the same order rule as TX. Set acc_err if rx_ferror or rx_perror. Zero the timeout counter.
  - If rx_cnt = WORD_BYTES-1: on the next edge load word_out with the assembled word, pulse word_out_valid for one cycle, set word_err = acc_err OR the current byte's error, then clear rx_cnt and acc_err.
  - Otherwise increment rx_cnt.
- A byte that arrives with an error is still counted. Word alignment is preserved.
- word_out and word_err hold their values until the next completed word.
- Timeout: while rx_cnt != 0 and rx_valid=0, the timeout counter increments each cycle. When it reaches RX_TIMEOUT: clear rx_cnt, acc_err and the counter, and pulse rx_timeout for one cycle. word_out is unchanged.
- Simultaneous rx_valid and timeout expiry: rx_valid wins. The byte is accepted and no rx_timeout pulse occurs.
- With WORD_BYTES=1, every rx_valid completes a word and a timeout can never occur.

Test Plan:
- Reset, then word_in=16'hA55A with word_valid held (WORD_BYTES=2, MSB_FIRST=1) and a transmitter model that is busy 10 cycles per byte -> tx_wr pulses twice, tx_data=8'hA5 then 8'h5A, one cycle high each; word_ready returns to 1 after the second busy falls.
- Loop tx_data back through the model receiver -> word_out=16'hA55A with a single word_out_valid pulse and word_err=0; repeat with MSB_FIRST=0 and check the byte order reverses on both paths.
- RX bytes 8'h12 (rx_perror=1), then 8'h34 -> word_out=16'h1234, word_err=1; the next clean word 16'hBEEF -> word_err=0.
- RX_TIMEOUT=8: one byte 8'h77, then idle 8 cycles -> rx_timeout pulses once, word_out unchanged; then bytes 8'h01, 8'h02 -> word_out=16'h0102.
- WORD_BYTES=4: word_in=32'hDEADBEEF -> tx_data sequence DE, AD, BE, EF; rx_valid on the same cycle the timeout would expire -> byte accepted, no rx_timeout pulse.
- Assert reset between the first and second TX byte and mid-RX word -> tx_wr=0 and all outputs at reset values at once; after release, a fresh word transfers correctly with no stale byte.
